// File: rtl/branch_hazard_ctrl_if.sv
// Control bundle between the branch-hazard controller and the surrounding
// fetch/EX datapath: instruction registers and flags in, mux selects,
// status and statistics out.
interface branch_hazard_ctrl_if #(
    parameter int IW   = 8,
    parameter int CNTW = 16
);
    logic [IW-1:0]   IR1;
    logic [IW-1:0]   IR2;
    logic            N;
    logic            Z;
    logic            IR1Sel;
    logic            ALUPC1;
    logic            PCSel;
    logic [1:0]      ALU1Sel;
    logic            FlagWrite;
    logic            busy;
    logic [CNTW-1:0] br_count;
    logic [CNTW-1:0] br_taken_count;

    // Datapath side: supplies instructions and flags, consumes controls.
    modport master (
        output IR1, IR2, N, Z,
        input  IR1Sel, ALUPC1, PCSel, ALU1Sel, FlagWrite, busy,
        input  br_count, br_taken_count
    );

    // Controller side.
    modport slave (
        input  IR1, IR2, N, Z,
        output IR1Sel, ALUPC1, PCSel, ALU1Sel, FlagWrite, busy,
        output br_count, br_taken_count
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// Branch-hazard controller: stalls decode on a conditional branch until the
// N/Z flags are valid, resolves it from a latched branch type, redirects the
// PC and refills the pipe. Also inserts a one-cycle load-use bubble and keeps
// saturating branch / taken statistics.
module branch_hazard_ctrl #(
    parameter int             IW       = 8,
    parameter int             OPW      = 4,
    parameter int             BR_DELAY = 2,
    parameter logic [OPW-1:0] OP_BPZ   = 4'b1101,
    parameter logic [OPW-1:0] OP_BNZ   = 4'b1001,
    parameter logic [OPW-1:0] OP_BZ    = 4'b0101,
    parameter logic [OPW-1:0] OP_LD    = 4'b0000,
    parameter bit             LU_EN    = 1'b1,
    parameter int             CNTW     = 16
) (
    input  logic                clock,
    input  logic                reset,
    branch_hazard_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_RUN     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_REFILL  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BT_NONE = 2'd0,
        BT_BPZ  = 2'd1,
        BT_BNZ  = 2'd2,
        BT_BZ   = 2'd3
    } br_type_t;

    state_t          r_state;
    logic [3:0]      r_wait_cnt;
    br_type_t        r_br_type;
    logic [CNTW-1:0] r_br_count;
    logic [CNTW-1:0] r_br_taken_count;

    logic [OPW-1:0]  w_op1;
    logic [OPW-1:0]  w_op2;
    logic [1:0]      w_ra1;
    logic [1:0]      w_rb1;
    logic [1:0]      w_ra2;
    logic            w_is_branch;
    logic            w_lu_hit;
    logic            w_taken;
    br_type_t        w_br_type_dec;
    logic            w_ir1_sel;
    logic            w_alupc1;
    logic            w_pc_sel;
    logic [1:0]      w_alu1_sel;
    logic            w_flag_write;
    logic            w_busy;
    logic            w_unused_ir2;

    assign w_op1 = bus.IR1[OPW-1:0];
    assign w_op2 = bus.IR2[OPW-1:0];
    assign w_ra1 = bus.IR1[IW-1:IW-2];
    assign w_rb1 = bus.IR1[IW-3:IW-4];
    assign w_ra2 = bus.IR2[IW-1:IW-2];

    // The rb field of the execute-stage instruction plays no part in the stall.
    assign w_unused_ir2 = ^bus.IR2;

    // Decode the branch type of IR1; BT_NONE means not a conditional branch.
    always_comb begin
        w_br_type_dec = BT_NONE;
        if (w_op1 == OP_BPZ) begin
            w_br_type_dec = BT_BPZ;
        end else if (w_op1 == OP_BNZ) begin
            w_br_type_dec = BT_BNZ;
        end else if (w_op1 == OP_BZ) begin
            w_br_type_dec = BT_BZ;
        end else begin
            w_br_type_dec = BT_NONE;
        end
    end

    assign w_is_branch = (w_br_type_dec != BT_NONE);

    // Load-use hazard: a load in EX writing a register the decode stage reads.
    assign w_lu_hit = (LU_EN == 1'b1) && !w_is_branch && (w_op2 == OP_LD) &&
                      ((w_ra2 == w_ra1) || (w_ra2 == w_rb1));

    // Branch outcome from the latched type, so IR2 need not be decoded again.
    always_comb begin
        w_taken = 1'b0;
        case (r_br_type)
            BT_BPZ:  w_taken = !bus.N;
            BT_BNZ:  w_taken = !bus.Z;
            BT_BZ:   w_taken = bus.Z;
            default: w_taken = 1'b0;
        endcase
    end

    // Datapath controls decoded from the current state and hazard conditions.
    always_comb begin
        w_ir1_sel    = 1'b1;
        w_alupc1     = 1'b1;
        w_pc_sel     = 1'b1;
        w_alu1_sel   = 2'b10;
        w_flag_write = 1'b1;
        w_busy       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_alupc1     = 1'b0;
                w_flag_write = 1'b0;
            end
            ST_RUN: begin
                if (w_is_branch || w_lu_hit) begin
                    w_ir1_sel = 1'b0;
                    w_alupc1  = 1'b0;
                end else begin
                    w_ir1_sel = 1'b1;
                    w_alupc1  = 1'b1;
                end
            end
            ST_WAIT: begin
                w_ir1_sel = 1'b0;
                w_alupc1  = 1'b0;
                w_busy    = 1'b1;
            end
            ST_RESOLVE: begin
                w_ir1_sel    = 1'b0;
                w_alupc1     = !w_taken;
                w_pc_sel     = !w_taken;
                w_alu1_sel   = 2'b01;
                w_flag_write = 1'b0;
                w_busy       = 1'b1;
            end
            ST_REFILL: begin
                w_ir1_sel = 1'b1;
                w_alupc1  = 1'b1;
            end
            default: begin
                w_ir1_sel = 1'b1;
                w_alupc1  = 1'b1;
            end
        endcase
    end

    // Sequencing, branch-type latch, wait countdown and saturating statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state          <= ST_INIT;
            r_wait_cnt       <= 4'd0;
            r_br_type        <= BT_NONE;
            r_br_count       <= {CNTW{1'b0}};
            r_br_taken_count <= {CNTW{1'b0}};
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_is_branch) begin
                        r_br_type <= w_br_type_dec;
                        if (BR_DELAY == 1) begin
                            r_state <= ST_RESOLVE;
                        end else begin
                            r_wait_cnt <= 4'(BR_DELAY - 1);
                            r_state    <= ST_WAIT;
                        end
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_state <= ST_RESOLVE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_RESOLVE: begin
                    if (r_br_count != {CNTW{1'b1}}) begin
                        r_br_count <= r_br_count + {{(CNTW-1){1'b0}}, 1'b1};
                    end
                    if (w_taken && (r_br_taken_count != {CNTW{1'b1}})) begin
                        r_br_taken_count <= r_br_taken_count + {{(CNTW-1){1'b0}}, 1'b1};
                    end
                    r_state <= ST_REFILL;
                end
                ST_REFILL: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.IR1Sel         = w_ir1_sel;
    assign bus.ALUPC1         = w_alupc1;
    assign bus.PCSel          = w_pc_sel;
    assign bus.ALU1Sel        = w_alu1_sel;
    assign bus.FlagWrite      = w_flag_write;
    assign bus.busy           = w_busy;
    assign bus.br_count       = r_br_count;
    assign bus.br_taken_count = r_br_taken_count;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Bench for branch_hazard_ctrl: four builds (default, BR_DELAY=4, LU_EN=0
// with BR_DELAY=1, 2-bit counters with BR_DELAY=1) share one stimulus stream
// and are each compared every cycle against a timeline model that counts
// cycles since branch detection.
module tb_branch_hazard_ctrl;
    localparam int NI = 4;
    localparam logic [3:0] OP_BPZ = 4'b1101;
    localparam logic [3:0] OP_BNZ = 4'b1001;
    localparam logic [3:0] OP_BZ  = 4'b0101;
    localparam logic [3:0] OP_LD  = 4'b0000;
    localparam int DLY  [NI] = '{2, 4, 1, 1};
    localparam bit LUE  [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};
    localparam int CMAX [NI] = '{65535, 65535, 65535, 3};

    typedef struct {
        bit         init;
        int         bc;     // 0 idle, else cycles since the branch was detected
        logic [3:0] typ;
        int         cnt;
        int         tcnt;
    } model_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ir1 = 8'h02;
    logic [7:0] ir2 = 8'h02;
    logic       n   = 1'b0;
    logic       z   = 1'b0;
    int         vectors = 0;
    int         miss    = 0;
    model_t     ms [NI];

    logic [6:0]  obs_ctl [NI];
    logic [15:0] obs_br  [NI];
    logic [15:0] obs_tk  [NI];

    always #5 clk = ~clk;

    branch_hazard_ctrl_if #(.IW(8), .CNTW(16)) bif0 ();
    branch_hazard_ctrl_if #(.IW(8), .CNTW(16)) bif1 ();
    branch_hazard_ctrl_if #(.IW(8), .CNTW(16)) bif2 ();
    branch_hazard_ctrl_if #(.IW(8), .CNTW(2))  bif3 ();

    assign bif0.IR1 = ir1; assign bif0.IR2 = ir2; assign bif0.N = n; assign bif0.Z = z;
    assign bif1.IR1 = ir1; assign bif1.IR2 = ir2; assign bif1.N = n; assign bif1.Z = z;
    assign bif2.IR1 = ir1; assign bif2.IR2 = ir2; assign bif2.N = n; assign bif2.Z = z;
    assign bif3.IR1 = ir1; assign bif3.IR2 = ir2; assign bif3.N = n; assign bif3.Z = z;

    branch_hazard_ctrl #(.BR_DELAY(2)) dut0 (.clock(clk), .reset(rst), .bus(bif0));
    branch_hazard_ctrl #(.BR_DELAY(4)) dut1 (.clock(clk), .reset(rst), .bus(bif1));
    branch_hazard_ctrl #(.BR_DELAY(1), .LU_EN(1'b0)) dut2 (.clock(clk), .reset(rst), .bus(bif2));
    branch_hazard_ctrl #(.BR_DELAY(1), .CNTW(2)) dut3 (.clock(clk), .reset(rst), .bus(bif3));

    assign obs_ctl[0] = {bif0.IR1Sel, bif0.ALUPC1, bif0.PCSel, bif0.ALU1Sel, bif0.FlagWrite, bif0.busy};
    assign obs_ctl[1] = {bif1.IR1Sel, bif1.ALUPC1, bif1.PCSel, bif1.ALU1Sel, bif1.FlagWrite, bif1.busy};
    assign obs_ctl[2] = {bif2.IR1Sel, bif2.ALUPC1, bif2.PCSel, bif2.ALU1Sel, bif2.FlagWrite, bif2.busy};
    assign obs_ctl[3] = {bif3.IR1Sel, bif3.ALUPC1, bif3.PCSel, bif3.ALU1Sel, bif3.FlagWrite, bif3.busy};
    assign obs_br[0] = bif0.br_count;  assign obs_tk[0] = bif0.br_taken_count;
    assign obs_br[1] = bif1.br_count;  assign obs_tk[1] = bif1.br_taken_count;
    assign obs_br[2] = bif2.br_count;  assign obs_tk[2] = bif2.br_taken_count;
    assign obs_br[3] = {14'd0, bif3.br_count};
    assign obs_tk[3] = {14'd0, bif3.br_taken_count};

    function automatic bit is_br(logic [7:0] ir);
        return (ir[3:0] == OP_BPZ) || (ir[3:0] == OP_BNZ) || (ir[3:0] == OP_BZ);
    endfunction

    function automatic bit taken_of(logic [3:0] op, logic nn, logic zz);
        if (op == OP_BPZ) return !nn;
        else if (op == OP_BNZ) return !zz;
        else return zz;
    endfunction

    // Expected {controls, br_count, br_taken_count} for build k this cycle.
    function automatic logic [38:0] exp_vec(int k);
        logic [6:0] c;
        bit st;
        bit t;
        if (ms[k].init) begin
            c = 7'b1011000;
        end else if (ms[k].bc == 0) begin
            st = is_br(ir1) || (LUE[k] && (ir2[3:0] == OP_LD) &&
                 ((ir2[7:6] == ir1[7:6]) || (ir2[7:6] == ir1[5:4])));
            c = {!st, !st, 1'b1, 2'b10, 1'b1, 1'b0};
        end else if (ms[k].bc < DLY[k]) begin
            c = 7'b0011011;
        end else if (ms[k].bc == DLY[k]) begin
            t = taken_of(ms[k].typ, n, z);
            c = {1'b0, !t, !t, 2'b01, 1'b0, 1'b1};
        end else begin
            c = 7'b1111010;
        end
        return {c, 16'(ms[k].cnt), 16'(ms[k].tcnt)};
    endfunction

    // Advance one clock and move every model along its branch timeline.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (rst) begin
                ms[k].init = 1'b1; ms[k].bc = 0; ms[k].cnt = 0; ms[k].tcnt = 0;
            end else if (ms[k].init) begin
                ms[k].init = 1'b0;
            end else if (ms[k].bc == 0) begin
                if (is_br(ir1)) begin
                    ms[k].bc  = 1;
                    ms[k].typ = ir1[3:0];
                end
            end else begin
                if (ms[k].bc == DLY[k]) begin
                    if (ms[k].cnt < CMAX[k]) ms[k].cnt++;
                    if (taken_of(ms[k].typ, n, z) && (ms[k].tcnt < CMAX[k])) ms[k].tcnt++;
                end
                ms[k].bc = (ms[k].bc > DLY[k]) ? 0 : ms[k].bc + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] e;
        rst = 1'b1; ir1 = 8'h02; ir2 = 8'h02;
        tick();
        for (int c = 0; c < 5; c++) begin
            rst = (c == 0);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL reset dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (obs_br[0] !== 16'd0 || obs_tk[0] !== 16'd0) begin
            miss++;
            $display("FAIL reset_counters: br=%0d tk=%0d, expected 0/0", obs_br[0], obs_tk[0]);
        end
    endtask

    task automatic test_branch_taken();
        logic [38:0] e;
        n = 1'b0; z = 1'b0;
        for (int c = 0; c < 10; c++) begin
            ir1 = (c == 0) ? 8'h0D : 8'h02;
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL bpz_taken dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (obs_br[0] !== 16'd1 || obs_tk[0] !== 16'd1) begin
            miss++;
            $display("FAIL bpz_counters: br=%0d tk=%0d, expected 1/1", obs_br[0], obs_tk[0]);
        end
    endtask

    task automatic test_not_taken();
        logic [38:0] e;
        for (int c = 0; c < 20; c++) begin
            rst = (c == 0);
            ir1 = (c == 2) ? 8'h05 : ((c == 11) ? 8'h09 : 8'h02);
            z   = (c >= 11);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL not_taken dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (obs_br[0] !== 16'd2 || obs_tk[0] !== 16'd0) begin
            miss++;
            $display("FAIL not_taken_counters: br=%0d tk=%0d, expected 2/0", obs_br[0], obs_tk[0]);
        end
    endtask

    task automatic test_bz_delay4();
        logic [38:0] e;
        int waits = 0;
        int res_c = -1;
        z = 1'b1;
        for (int c = 0; c < 10; c++) begin
            ir1 = (c == 0) ? 8'h05 : 8'h02;
            @(negedge clk);
            if (obs_ctl[1][0] === 1'b1 && obs_ctl[1][3:2] === 2'b10) waits++;
            if (obs_ctl[1][3:2] === 2'b01 && res_c < 0) res_c = c;
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL bz_delay4 dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (waits != 3 || res_c != 4) begin
            miss++;
            $display("FAIL delay4_timing: wait cycles=%0d resolve at t+%0d, expected 3 and t+4", waits, res_c);
        end
    endtask

    task automatic test_load_use();
        logic [38:0] e;
        logic [1:0] stall_pair;
        stall_pair = 2'b00;
        for (int c = 0; c < 4; c++) begin
            ir2 = (c == 0) ? 8'h40 : 8'h02;
            ir1 = (c == 0) ? 8'h12 : 8'h02;
            @(negedge clk);
            if (c == 0) stall_pair = {obs_ctl[0][6], obs_ctl[2][6]};
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL load_use dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (stall_pair !== 2'b01) begin
            miss++;
            $display("FAIL load_use_enable: IR1Sel lu_on/lu_off=%b, expected 01", stall_pair);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [38:0] e;
        logic [6:0]  ctl_after;
        ctl_after = 7'b0;
        z = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rst = (c == 0) || (c == 3);
            ir1 = (c == 2) ? 8'h05 : 8'h02;
            @(negedge clk);
            if (c == 4) ctl_after = obs_ctl[0];
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL reset_wait dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (ctl_after !== 7'b1011000) begin
            miss++;
            $display("FAIL reset_wait_init: ctl=%b, expected 1011000", ctl_after);
        end
    endtask

    task automatic test_saturation();
        logic [38:0] e;
        z = 1'b1;
        for (int c = 0; c < 50; c++) begin
            rst = (c == 0);
            ir1 = (c < 40) ? 8'h05 : 8'h02;
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL saturate dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        vectors++;
        if (obs_br[3] !== 16'd3 || obs_tk[3] !== 16'd3) begin
            miss++;
            $display("FAIL saturate_hold: br=%0d tk=%0d, expected 3/3", obs_br[3], obs_tk[3]);
        end
    endtask

    task automatic test_random();
        logic [38:0] e;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            ir1 = 8'($urandom);
            ir2 = ($urandom_range(0, 2) == 0) ? {2'($urandom), 2'($urandom), 4'b0000} : 8'($urandom);
            n   = 1'($urandom);
            z   = 1'($urandom);
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                e = exp_vec(k); vectors++;
                if ({obs_ctl[k], obs_br[k], obs_tk[k]} !== e) begin
                    miss++;
                    $display("FAIL random dut%0d c%0d: ctl=%b br=%0d tk=%0d, expected ctl=%b br=%0d tk=%0d",
                             k, c, obs_ctl[k], obs_br[k], obs_tk[k], e[38:32], e[31:16], e[15:0]);
                end
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            ms[k].init = 1'b1; ms[k].bc = 0; ms[k].typ = 4'd0; ms[k].cnt = 0; ms[k].tcnt = 0;
        end
        test_reset();
        test_branch_taken();
        test_not_taken();
        test_bz_delay4();
        test_load_use();
        test_reset_mid_wait();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
Parametrised successor to the pipeline branch-hazard FSM. It detects conditional branches (BPZ/BNZ/BZ) in IR1 and inserts a configurable number of bubbles until the N/Z flags are valid. It then resolves the branch, redirects the PC, and refills the pipe. New in this generation: a latched branch type, so resolution does not re-decode IR2; a one-cycle load-use stall; and saturating branch/taken statistics counters. It sits beside the fetch and EX control blocks and drives the IR1 mux, the PC-increment mux, the PC source mux, ALU1 select and FlagWrite.

Parameters:
IW, 8, instruction width; opcode is IR[OPW-1:0], register fields are IR[IW-1:IW-2] (ra) and IR[IW-3:IW-4] (rb)
OPW, 4, opcode field width
BR_DELAY, 2, cycles from branch detect to resolve; legal range 1..15
OP_BPZ, 4'b1101, branch-if-positive-or-zero opcode
OP_BNZ, 4'b1001, branch-if-not-zero opcode
OP_BZ, 4'b0101, branch-if-zero opcode
OP_LD, 4'b0000, load opcode; destination is ra
LU_EN, 1, 1 = load-use stall enabled
CNTW, 16, statistics counter width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
IR1  in  IW  instruction in decode stage
IR2  in  IW  instruction in execute stage
N  in  1  negative flag (valid in RESOLVE)
Z  in  1  zero flag (valid in RESOLVE)
IR1Sel  out  1  1 = pass IR1, 0 = inject NOP
ALUPC1  out  1  1 = PC+1, 0 = freeze PC
PCSel  out  1  1 = sequential PC, 0 = branch target
ALU1Sel  out  2  2'b10 = R1, 2'b01 = PC/offset path
FlagWrite  out  1  flag register write enable
busy  out  1  1 while branch handling is in progress (WAIT/RESOLVE)
br_count  out  CNTW  branches resolved
br_taken_count  out  CNTW  branches taken

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising clock edge.
- Reset takes priority over everything, including mid-branch. It forces state=INIT, wait counter=0, br_type=0 and both statistics counters=0.
- Outputs are Moore/Mealy combinational from the state, IR1, IR2, N and Z. All of them are defined in every state, so no latches are inferred.
- INIT (the cycle after reset): IR1Sel=1, ALUPC1=0, PCSel=1, ALU1Sel=10, FlagWrite=0, busy=0. Next state is RUN.
- RUN, default outputs: IR1Sel=1, ALUPC1=1, PCSel=1, ALU1Sel=10, FlagWrite=1, busy=0.
- RUN, branch in IR1 (opcode is BPZ, BNZ or BZ):
  - Outputs IR1Sel=0 and ALUPC1=0.
  - Latch br_type (bpz/bnz/bz) from IR1.
  - If BR_DELAY=1, next state is RESOLVE. Otherwise load the wait counter with BR_DELAY-1 and go to WAIT.
- RUN, load-use: applies when LU_EN=1, IR1 is not a branch, IR2 opcode is OP_LD, and IR2.ra equals IR1.ra or IR1.rb.
  - Outputs IR1Sel=0 and ALUPC1=0 for that cycle.
  - The state stays RUN. The injected NOP clears the condition on the next cycle.
  - Branch detection has priority over load-use.
- WAIT: IR1Sel=0, ALUPC1=0, PCSel=1, ALU1Sel=10, FlagWrite=1, busy=1.
  - The counter decrements each cycle. When it is 1, next state is RESOLVE.
  - IR1 and IR2 are ignored in this state.
- RESOLVE: FlagWrite=0, IR1Sel=0, ALU1Sel=01, busy=1.
  - Taken conditions: bpz when !N, bnz when !Z, bz when Z.
  - Taken: PCSel=0, ALUPC1=0. Not taken: PCSel=1, ALUPC1=1.
  - br_count increments, and br_taken_count increments if taken. Both saturate at all-ones.
  - Next state is REFILL.
- REFILL: IR1Sel=1, ALUPC1=1, PCSel=1, ALU1Sel=10, FlagWrite=1, busy=0. Next state is RUN.
  - A branch appearing in IR1 during REFILL is not detected until the following RUN cycle. This equals the one-cycle refill of the previous generation.
- Latency: a branch detected at cycle t resolves at cycle t+BR_DELAY and returns to RUN at cycle t+BR_DELAY+2.
- Illegal or unused state encodings recover to RUN with the RUN default outputs.

Test Plan:
- Reset, then IR1 = NOP (8'h00 is OP_LD, so use 8'h02) → INIT cycle has ALUPC1=0, FlagWrite=0; RUN follows with IR1Sel=1, ALUPC1=1, PCSel=1, ALU1Sel=10. Both counters are 0.
- BR_DELAY=2, IR1=8'h0D (BPZ), N=0 at RESOLVE → sequence RUN(IR1Sel=0) → WAIT → RESOLVE(PCSel=0, ALU1Sel=01, FlagWrite=0) → REFILL → RUN. br_count=1, br_taken_count=1.
- BZ with Z=0, then BNZ with Z=1 → both not taken: PCSel=1, ALUPC1=1 at RESOLVE. br_count=2, br_taken_count=0.
- BR_DELAY=4 build, BZ with Z=1 → exactly 3 WAIT cycles with busy=1; taken at cycle t+4.
- IR2=8'h40 (LD, ra=01), IR1=8'h12 (rb=01) → one cycle of IR1Sel=0, ALUPC1=0, state stays RUN. With LU_EN=0 there is no stall.
- Reset asserted during WAIT → next cycle is INIT; counters cleared; no RESOLVE outputs appear. Also drive 2^CNTW+3 taken branches → both counters hold at all-ones.
